// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : RV32 opcode constants, fetch NOP word and fetch FSM state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : PC owner issuing single-outstanding imem fetches, presenting one
//          instruction at a time to the core, with execute-stage redirects.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nx;
  logic            r_drop;
  logic            w_drop_nx;
  logic            r_req_valid;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_misalign;
  logic            w_hs;
  logic            w_load;
  logic            w_clear;
  logic [XLEN-1:0] w_redir_pc;

  assign w_hs       = r_req_valid && imem_req_ready;
  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_drop_nx  = r_drop;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    unique case (r_state)
      S_REQ: begin
        if (w_hs) begin
          w_state_nx = S_WAIT;
          w_drop_nx  = redirect_valid;
        end
        if (redirect_valid) w_pc_nx = w_redir_pc;
      end
      S_WAIT: begin
        // A response coinciding with a redirect is the stale one being dropped.
        if (imem_rsp_valid) begin
          w_state_nx = S_REQ;
          w_drop_nx  = 1'b0;
          if (!r_drop && !redirect_valid) begin
            w_state_nx = S_HOLD;
            w_load     = 1'b1;
          end
        end else if (redirect_valid) begin
          w_drop_nx = 1'b1;
        end
        if (redirect_valid) w_pc_nx = w_redir_pc;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_state_nx = S_REQ;
          w_clear    = 1'b1;
          w_pc_nx    = w_redir_pc;
        end else if (instr_ready) begin
          w_state_nx = S_REQ;
          w_clear    = 1'b1;
          w_pc_nx    = r_pc + C_PC_STEP;
        end
      end
      default: w_state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_misalign    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_drop      <= w_drop_nx;
      r_req_valid <= (w_state_nx == S_REQ);
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
      if (w_load) begin
        r_instr       <= imem_rsp_data;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
      end else if (w_clear) begin
        r_instr       <= NOP_INSTR;
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign opcode         = r_instr[6:0];
  assign misalign_err   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Directed vector table plus randomized run against a stream model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = {25'h0004004, OP_I_TYPE};
  localparam logic [31:0] I2  = {25'h0010000, OP_JAL};
  localparam logic [31:0] I3  = {25'h00002A0, OP_LUI};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents: odd multiplier keeps every address distinct.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    bit          rn, rr, rv;
    logic [31:0] rd;
    bit          ir, xv;
    logic [31:0] xp;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_instr;
    bit          e_cpc;
    logic [31:0] e_ipc;
    bit          e_mis;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rn, bit rr, bit rv, logic [31:0] rd, bit ir, bit xv,
                              logic [31:0] xp, bit erv, logic [31:0] ea, bit eiv,
                              logic [31:0] ei, bit ecp, logic [31:0] eipc, bit em);
    vec_t v;
    v.rn = rn; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xp = xp;
    v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_instr = ei;
    v.e_cpc = ecp; v.e_ipc = eipc; v.e_mis = em;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_pc, paddr, haddr, rpc, exp_instr;
    bit          exp_mis, pend, hs, cons, rf, rd, pv;
    int          pcnt, deliv;

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // rn rr rv rd        ir xv xp            | erv addr        eiv instr cpc ipc        mis
    vt.push_back(mk(0,0,0,0,           0,0,0,            0,0,            0,NOP,1,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            1,0,            0,NOP,1,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,1,0,           0));
    vt.push_back(mk(1,1,1,I0,          0,0,0,            0,0,            1,I0, 1,0,           0));
    for (int k = 0; k < 5; k++)
      vt.push_back(mk(1,1,0,0,         0,0,0,            0,0,            1,I0, 1,0,           0));
    vt.push_back(mk(1,0,0,0,           1,0,0,            1,32'h4,        0,NOP,0,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,0,0,           0));
    vt.push_back(mk(1,0,0,0,           0,1,32'h100,      0,0,            0,NOP,0,0,           0));
    vt.push_back(mk(1,0,1,32'hDEADBEEF,0,0,0,            1,32'h100,      0,NOP,0,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,0,0,           0));
    vt.push_back(mk(1,0,1,I1,          0,0,0,            0,0,            1,I1, 1,32'h100,     0));
    vt.push_back(mk(1,0,0,0,           1,1,32'h200,      1,32'h200,      0,NOP,0,0,           0));
    vt.push_back(mk(1,0,0,0,           0,1,32'h102,      1,32'h100,      0,NOP,0,0,           1));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,0,0,           1));
    vt.push_back(mk(1,0,1,I2,          0,0,0,            0,0,            1,I2, 1,32'h100,     1));
    vt.push_back(mk(0,0,0,0,           0,0,0,            0,0,            0,NOP,1,0,           0));
    vt.push_back(mk(1,0,0,0,           0,1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 0,NOP,0,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,0,0,           0));
    vt.push_back(mk(1,0,1,I3,          0,0,0,            0,0,            1,I3, 1,32'hFFFFFFFC,0));
    vt.push_back(mk(1,0,0,0,           1,0,0,            1,32'h0,        0,NOP,0,0,           0));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(1,0,0,0,         0,0,0,            1,32'h0,        0,NOP,0,0,           0));
    vt.push_back(mk(1,1,0,0,           0,0,0,            0,0,            0,NOP,0,0,           0));

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rn; imem_req_ready = vt[i].rr; imem_rsp_valid = vt[i].rv;
      imem_rsp_data = vt[i].rd; instr_ready = vt[i].ir;
      redirect_valid = vt[i].xv; redirect_pc = vt[i].xp;
      @(posedge clk); #1;
      chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("v%0d req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].e_iv));
      chk($sformatf("v%0d instr", i), instr, vt[i].e_instr);
      chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(vt[i].e_instr[6:0]));
      if (vt[i].e_cpc) chk($sformatf("v%0d instr_pc", i), instr_pc, vt[i].e_ipc);
      chk($sformatf("v%0d misalign", i), 32'(misalign_err), 32'(vt[i].e_mis));
      if (i == 3) chk("addi_opcode", 32'(opcode), 32'(OP_I_TYPE));
    end

    // Randomized run: the model only tracks which PC the core must see next.
    exp_pc = '0; exp_mis = 1'b0; pend = 1'b0; pcnt = 0; paddr = '0; deliv = 0; pv = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_n = !(cyc == 0 || cyc == 2000);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (pend && pcnt == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = memf(paddr);
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      end
      instr_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      hs = imem_req_valid && imem_req_ready; cons = instr_valid && instr_ready;
      rf = imem_rsp_valid; rd = redirect_valid; rpc = redirect_pc;
      haddr = imem_req_addr; pv = instr_valid;
      @(posedge clk); #1;
      if (!rst_n) begin
        exp_pc = '0; exp_mis = 1'b0; pend = 1'b0; pv = 1'b0; cons = 1'b0; rd = 1'b0;
      end else begin
        if (hs) chk("single_outstanding", 32'(pend), 32'(0));
        if (rf) pend = 1'b0;
        else if (pend && pcnt > 0) pcnt--;
        if (hs) begin
          pend = 1'b1; paddr = haddr; pcnt = $urandom_range(0, 2);
        end
        if (rd) begin
          exp_pc = rpc & 32'hFFFF_FFFC;
          if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
        end else if (cons) begin
          exp_pc = exp_pc + 32'd4;
          deliv++;
        end
      end
      exp_instr = instr_valid ? memf(exp_pc) : NOP;
      chk("r_misalign", 32'(misalign_err), 32'(exp_mis));
      chk("r_instr", instr, exp_instr);
      chk("r_opcode", 32'(opcode), 32'(exp_instr[6:0]));
      if (instr_valid) chk("r_instr_pc", instr_pc, exp_pc);
      if (imem_req_valid) chk("r_req_addr", imem_req_addr, exp_pc);
      if (pv && !cons && !rd) chk("r_hold_valid", 32'(instr_valid), 32'(1));
      if (cons || rd) chk("r_valid_drop", 32'(instr_valid), 32'(0));
      chk("r_req_vs_instr", 32'(imem_req_valid && instr_valid), 32'(0));
    end
    chk("r_progress", 32'(deliv > 100), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
